rx_deframer: RTL and testbench
==============================

RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 Parameter SYMS_PER_WORD, default 2: 10-bit symbols packed per output word; legal range 1..4.
REQ-002 Parameter LOCK_COUNT, default 3: consecutive boundary-aligned commas needed to enter LOCKED; legal range 1..15.
REQ-003 Parameter LOSS_COUNT, default 4: consecutive misaligned commas that drop lock; legal range 1..15.
REQ-004 Port clk_x8, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port bit_in, input, 1: recovered serial bit, LSB (bit a) of each symbol first.
REQ-007 Port bit_valid, input, 1: one-cycle strobe qualifying bit_in.
REQ-008 Port d_out, output, 8*SYMS_PER_WORD: decoded word; first-received symbol in bits [7:0].
REQ-009 Port d_out_valid, output, 1: one-cycle pulse, d_out valid.
REQ-010 Port locked, output, 1: high in LOCKED state.
REQ-011 Port reframe, output, 1: one-cycle pulse when symbol alignment is (re)established.
REQ-012 Port word_drop, output, 1: one-cycle pulse when a partial word is discarded.

Function
REQ-013 Window = last 10 received bits including the current bit_in, held in a shift register shifting right (new bit enters bit 9).
REQ-014 Comma = window equal to 10'h17C (K28.5, RD-) or 10'h283 (K28.5, RD+), per the shared include constants.
REQ-015 A 4-bit bit counter advances per bit_valid; a symbol boundary occurs when it completes 10 bits; it wraps to 0 at each boundary.
REQ-016 Data symbols are decoded by an instance of the existing decode_8b10b; commas are never output as data.
REQ-017 FSM states HUNT, SYNC, LOCKED; reset state HUNT.
REQ-018 HUNT: any comma forces the bit counter to 0, pulses reframe, clears the lock counter to 1, and moves to SYNC (or to LOCKED when LOCK_COUNT=1).
REQ-019 SYNC: a comma at a boundary increments the lock counter; reaching LOCK_COUNT moves to LOCKED.
REQ-020 SYNC: a comma off-boundary realigns, pulses reframe, sets the lock counter to 1, and stays in SYNC; data symbols leave the lock counter unchanged.
REQ-021 LOCKED: an aligned comma clears the miss counter.
REQ-022 LOCKED: a misaligned comma increments the miss counter and does not realign; reaching LOSS_COUNT moves to HUNT, clears the counters and discards the partial word.
REQ-023 Packing occurs only in LOCKED; decoded data symbols accumulate in order, and after SYMS_PER_WORD of them d_out updates and d_out_valid pulses.
REQ-024 Latency: d_out_valid is asserted in the cycle after the bit_valid that completes the last symbol.
REQ-025 An aligned comma arriving with 1..SYMS_PER_WORD-1 symbols accumulated discards them and pulses word_drop; with none accumulated, no pulse.
REQ-026 Leaving LOCKED with a non-empty partial word pulses word_drop.
REQ-027 Comma detection takes priority over the boundary/data path in the same bit.
REQ-028 With bit_valid low, all state holds and all pulse outputs are 0.
REQ-029 d_out holds its last value between valid pulses.

Reset
REQ-030 While rst_n is sampled low: the FSM goes to HUNT and the shift register, bit counter, lock/miss counters and symbol accumulator clear to 0.
REQ-031 While rst_n is sampled low: d_out, d_out_valid, locked, reframe, word_drop and the stats counters are 0.
REQ-032 Reset mid-word discards the partial word without a word_drop pulse.

Configuration
REQ-033 With macro RX_DEFRAMER_STATS_EN defined, the block adds output ports comma_cnt[15:0] and realign_cnt[15:0]: 16-bit saturating counters of detected commas and reframe pulses, cleared by reset.
REQ-034 Without RX_DEFRAMER_STATS_EN, those ports and counters do not exist and all other behaviour is identical.

Verification
REQ-035 Defaults; 3 aligned RD- commas then data symbols for 0xA5, 0x3C -> locked rises after the 3rd comma; one d_out_valid with d_out=16'h3CA5.
REQ-036 LOCKED; 4 commas offset by 3 bits -> locked falls after the 4th comma, no reframe during the misses, reframe on the next comma in HUNT.
REQ-037 LOCKED; 1 data symbol, then an aligned comma -> word_drop pulses once, no d_out_valid.
REQ-038 SYMS_PER_WORD=1, LOCK_COUNT=1; one comma then 0xFF -> locked after that one comma; d_out=8'hFF with d_out_valid one cycle after the last bit.
REQ-039 rst_n low for 1 cycle mid-word in LOCKED -> all outputs 0, locked=0, no word_drop.
REQ-040 RX_DEFRAMER_STATS_EN defined; 5 commas including 1 realignment -> comma_cnt=5, realign_cnt=2 (initial plus realign).

Source files
------------

// File: rtl/rx_deframer.sv
// Serial 8b/10b receive deframer: comma hunt, alignment lock/loss FSM and word packing.
// Optional build macro RX_DEFRAMER_STATS_EN adds comma_cnt / realign_cnt statistics ports.

module decode_8b10b (
  input  logic [9:0] sym,
  output logic [7:0] data
);
  logic [5:0] abcdei;
  logic [3:0] fghj;
  logic [4:0] lo;
  logic [2:0] hi;

  // Bit a is the first bit on the wire and lives in sym[0].
  assign abcdei = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
  assign fghj   = {sym[6], sym[7], sym[8], sym[9]};
  assign data   = {hi, lo};

  always_comb begin
    case (abcdei)
      6'b100111, 6'b011000: lo = 5'd0;
      6'b011101, 6'b100010: lo = 5'd1;
      6'b101101, 6'b010010: lo = 5'd2;
      6'b110001:            lo = 5'd3;
      6'b110101, 6'b001010: lo = 5'd4;
      6'b101001:            lo = 5'd5;
      6'b011001:            lo = 5'd6;
      6'b111000, 6'b000111: lo = 5'd7;
      6'b111001, 6'b000110: lo = 5'd8;
      6'b100101:            lo = 5'd9;
      6'b010101:            lo = 5'd10;
      6'b110100:            lo = 5'd11;
      6'b001101:            lo = 5'd12;
      6'b101100:            lo = 5'd13;
      6'b011100:            lo = 5'd14;
      6'b010111, 6'b101000: lo = 5'd15;
      6'b011011, 6'b100100: lo = 5'd16;
      6'b100011:            lo = 5'd17;
      6'b010011:            lo = 5'd18;
      6'b110010:            lo = 5'd19;
      6'b001011:            lo = 5'd20;
      6'b101010:            lo = 5'd21;
      6'b011010:            lo = 5'd22;
      6'b111010, 6'b000101: lo = 5'd23;
      6'b110011, 6'b001100: lo = 5'd24;
      6'b100110:            lo = 5'd25;
      6'b010110:            lo = 5'd26;
      6'b110110, 6'b001001: lo = 5'd27;
      6'b001110, 6'b001111, 6'b110000: lo = 5'd28;
      6'b101110, 6'b010001: lo = 5'd29;
      6'b011110, 6'b100001: lo = 5'd30;
      6'b101011, 6'b010100: lo = 5'd31;
      default:              lo = 5'd0;
    endcase
  end

  always_comb begin
    case (fghj)
      4'b1011, 4'b0100: hi = 3'd0;
      4'b1001:          hi = 3'd1;
      4'b0101:          hi = 3'd2;
      4'b1100, 4'b0011: hi = 3'd3;
      4'b1101, 4'b0010: hi = 3'd4;
      4'b1010:          hi = 3'd5;
      4'b0110:          hi = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: hi = 3'd7;
      default:          hi = 3'd0;
    endcase
  end
endmodule

module rx_deframer #(
  parameter int SYMS_PER_WORD = 2,
  parameter int LOCK_COUNT    = 3,
  parameter int LOSS_COUNT    = 4
) (
  input  logic                       clk_x8,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic [8*SYMS_PER_WORD-1:0] d_out,
  output logic                       d_out_valid,
  output logic                       locked,
  output logic                       reframe,
  output logic                       word_drop
`ifdef RX_DEFRAMER_STATS_EN
  ,
  output logic [15:0]                comma_cnt,
  output logic [15:0]                realign_cnt
`endif
);
  localparam int         W         = 8 * SYMS_PER_WORD;
  localparam logic [9:0] COMMA_NEG = 10'h17C;
  localparam logic [9:0] COMMA_POS = 10'h283;
  localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N    = 4'(LOSS_COUNT);
  localparam logic [2:0] LAST_SLOT = 3'(SYMS_PER_WORD - 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [8:0]     hist_q;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]     lock_cnt_q, lock_cnt_d;
  logic [3:0]     miss_cnt_q, miss_cnt_d;
  logic [W-1:0]   acc_q, acc_d, word_next, d_out_d;
  logic [2:0]     acc_cnt_q, acc_cnt_d;
  logic           dv_d, reframe_d, drop_d;
  logic [9:0]     window;
  logic           is_comma, at_boundary;
  logic [7:0]     dec_data;

  // The window includes the bit being presented now, so a comma is seen on its last bit.
  assign window      = {bit_in, hist_q};
  assign is_comma    = (window == COMMA_NEG) || (window == COMMA_POS);
  assign at_boundary = (bit_cnt_q == 4'd9);
  assign locked      = (state_q == LOCKED);

  decode_8b10b u_dec (.sym(window), .data(dec_data));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    lock_cnt_d = lock_cnt_q;
    miss_cnt_d = miss_cnt_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    d_out_d    = d_out;
    dv_d       = 1'b0;
    reframe_d  = 1'b0;
    drop_d     = 1'b0;
    word_next  = acc_q;
    for (int s = 0; s < SYMS_PER_WORD; s++)
      if (acc_cnt_q == 3'(s)) word_next[8*s +: 8] = dec_data;

    if (bit_valid) begin
      bit_cnt_d = at_boundary ? 4'd0 : bit_cnt_q + 4'd1;
      case (state_q)
        HUNT: if (is_comma) begin
          bit_cnt_d  = 4'd0;
          reframe_d  = 1'b1;
          lock_cnt_d = 4'd1;
          state_d    = (LOCK_COUNT == 1) ? LOCKED : SYNC;
        end
        SYNC: if (is_comma) begin
          if (at_boundary) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
            if (lock_cnt_q + 4'd1 == LOCK_N) state_d = LOCKED;
          end else begin
            bit_cnt_d  = 4'd0;
            reframe_d  = 1'b1;
            lock_cnt_d = 4'd1;
          end
        end
        LOCKED: if (is_comma) begin
          // A comma never reaches the packer; it either confirms alignment or counts as a miss.
          if (at_boundary) begin
            miss_cnt_d = 4'd0;
            drop_d     = (acc_cnt_q != 3'd0);
            acc_cnt_d  = 3'd0;
            acc_d      = '0;
          end else if (miss_cnt_q + 4'd1 == LOSS_N) begin
            state_d    = HUNT;
            lock_cnt_d = 4'd0;
            miss_cnt_d = 4'd0;
            drop_d     = (acc_cnt_q != 3'd0);
            acc_cnt_d  = 3'd0;
            acc_d      = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
        end else if (at_boundary) begin
          if (acc_cnt_q == LAST_SLOT) begin
            d_out_d   = word_next;
            dv_d      = 1'b1;
            acc_cnt_d = 3'd0;
            acc_d     = '0;
          end else begin
            acc_d     = word_next;
            acc_cnt_d = acc_cnt_q + 3'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_x8) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q     <= HUNT;
      hist_q      <= '0;
      bit_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      d_out       <= '0;
      d_out_valid <= 1'b0;
      reframe     <= 1'b0;
      word_drop   <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (bit_valid) hist_q <= window[9:1];
      bit_cnt_q   <= bit_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      d_out       <= d_out_d;
      d_out_valid <= dv_d;
      reframe     <= reframe_d;
      word_drop   <= drop_d;
    end
  end

`ifdef RX_DEFRAMER_STATS_EN
  always_ff @(posedge clk_x8) begin
    if (!rst_n) begin
      comma_cnt   <= '0;
      realign_cnt <= '0;
    end else begin
      if (bit_valid && is_comma && comma_cnt != 16'hFFFF) comma_cnt <= comma_cnt + 16'd1;
      if (reframe_d && realign_cnt != 16'hFFFF) realign_cnt <= realign_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rx_deframer.sv
// Scoreboard bench for rx_deframer: default instance plus a SYMS_PER_WORD=1 / LOCK_COUNT=1 instance.
module tb_rx_deframer;
  logic        clk_x8 = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_valid2 = 1'b0;
  logic [15:0] d_out;
  logic        d_out_valid, locked, reframe, word_drop;
  logic [7:0]  d_out2;
  logic        d_out_valid2, locked2, reframe2, word_drop2;
`ifdef RX_DEFRAMER_STATS_EN
  logic [15:0] comma_cnt, realign_cnt, comma_cnt2, realign_cnt2;
`endif

  // Codes in wire order: leftmost bit (a) is sent first.
  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] C_A5  = 10'b1010011010;
  localparam logic [9:0] C_3C  = 10'b0011101001;
  localparam logic [9:0] C_00  = 10'b1001110100;
  localparam logic [9:0] C_FF  = 10'b1010111110;

  typedef struct {
    logic [15:0] data;
    bit          any;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0, failed = 0;
  int   reframe_seen = 0, drop_seen = 0, dv_seen = 0;
  int   reframe2_seen = 0, dv2_seen = 0;

  always #5 clk_x8 = ~clk_x8;

  rx_deframer #(.SYMS_PER_WORD(2), .LOCK_COUNT(3), .LOSS_COUNT(4)) u_dut (
    .clk_x8(clk_x8), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .d_out(d_out), .d_out_valid(d_out_valid), .locked(locked),
    .reframe(reframe), .word_drop(word_drop)
`ifdef RX_DEFRAMER_STATS_EN
    , .comma_cnt(comma_cnt), .realign_cnt(realign_cnt)
`endif
  );

  rx_deframer #(.SYMS_PER_WORD(1), .LOCK_COUNT(1), .LOSS_COUNT(4)) u_dut2 (
    .clk_x8(clk_x8), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid2),
    .d_out(d_out2), .d_out_valid(d_out_valid2), .locked(locked2),
    .reframe(reframe2), .word_drop(word_drop2)
`ifdef RX_DEFRAMER_STATS_EN
    , .comma_cnt(comma_cnt2), .realign_cnt(realign_cnt2)
`endif
  );

  // Output monitor: counts pulses and pops the scoreboard on every delivered word.
  always @(negedge clk_x8) begin
    exp_t e;
    if (reframe === 1'b1) reframe_seen++;
    if (word_drop === 1'b1) drop_seen++;
    if (reframe2 === 1'b1) reframe2_seen++;
    if (d_out_valid2 === 1'b1) dv2_seen++;
    if (d_out_valid === 1'b1) begin
      dv_seen++;
      if (sb_q.size() == 0) begin
        tests++; failed++;
        $display("FAIL unexpected_word: got d_out=%h, expected no word", d_out);
      end else begin
        e = sb_q.pop_front();
        if (!e.any) begin
          tests++;
          if (d_out !== e.data) begin
            failed++;
            $display("FAIL word_data: got d_out=%h, expected %h", d_out, e.data);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b, input bit to2);
    @(negedge clk_x8);
    bit_in = b;
    if (to2) bit_valid2 = 1'b1; else bit_valid = 1'b1;
    @(negedge clk_x8);
    bit_valid  = 1'b0;
    bit_valid2 = 1'b0;
  endtask

  task automatic send_sym(input logic [9:0] code, input bit to2);
    for (int i = 9; i >= 0; i--) send_bit(code[i], to2);
  endtask

  task automatic settle();
    @(negedge clk_x8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_x8);
    tests++; if (d_out !== 16'h0) begin failed++; $display("FAIL reset_d_out: got %h, expected 0000", d_out); end
    tests++; if (d_out_valid !== 1'b0) begin failed++; $display("FAIL reset_dv: got %b, expected 0", d_out_valid); end
    tests++; if (locked !== 1'b0) begin failed++; $display("FAIL reset_locked: got %b, expected 0", locked); end
    tests++; if (reframe !== 1'b0 || word_drop !== 1'b0) begin
      failed++; $display("FAIL reset_pulses: got reframe=%b word_drop=%b, expected 0 0", reframe, word_drop);
    end
`ifdef RX_DEFRAMER_STATS_EN
    tests++; if (comma_cnt !== 16'h0 || realign_cnt !== 16'h0) begin
      failed++; $display("FAIL reset_stats: got %0d/%0d, expected 0/0", comma_cnt, realign_cnt);
    end
`endif
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_single();
    int r0, d0;
    logic [9:0] code;
    r0 = reframe2_seen; d0 = dv2_seen; code = C_FF;
    send_sym(K_NEG, 1'b1); settle();
    tests++; if (locked2 !== 1'b1) begin failed++; $display("FAIL single_locked: got %b, expected 1", locked2); end
    tests++; if (reframe2_seen - r0 != 1) begin
      failed++; $display("FAIL single_reframe: got %0d pulses, expected 1", reframe2_seen - r0);
    end
    for (int i = 9; i >= 1; i--) send_bit(code[i], 1'b1);
    tests++; if (dv2_seen != d0) begin failed++; $display("FAIL single_early: got %0d words, expected 0", dv2_seen - d0); end
    @(negedge clk_x8);
    bit_in = code[0]; bit_valid2 = 1'b1;
    @(posedge clk_x8); #1;
    tests++; if (d_out_valid2 !== 1'b1 || d_out2 !== 8'hFF) begin
      failed++; $display("FAIL single_word: got valid=%b d_out=%h, expected 1 ff", d_out_valid2, d_out2);
    end
    @(negedge clk_x8); bit_valid2 = 1'b0;
    settle();
    tests++; if (dv2_seen - d0 != 1) begin failed++; $display("FAIL single_count: got %0d words, expected 1", dv2_seen - d0); end
  endtask

  task automatic test_lock();
    int r0, d0;
    r0 = reframe_seen; d0 = dv_seen;
    send_sym(K_NEG, 1'b0); settle();
    tests++; if (reframe_seen - r0 != 1) begin failed++; $display("FAIL lock_reframe: got %0d, expected 1", reframe_seen - r0); end
    send_sym(K_NEG, 1'b0); settle();
    tests++; if (locked !== 1'b0) begin failed++; $display("FAIL lock_early: got %b, expected 0", locked); end
    send_sym(K_NEG, 1'b0); settle();
    tests++; if (locked !== 1'b1) begin failed++; $display("FAIL lock_rise: got %b, expected 1", locked); end
    tests++; if (reframe_seen - r0 != 1) begin failed++; $display("FAIL lock_extra_reframe: got %0d, expected 1", reframe_seen - r0); end
    sb_q.push_back('{16'h3CA5, 1'b0});
    send_sym(C_A5, 1'b0);
    send_sym(C_3C, 1'b0);
    tests++; if (d_out_valid !== 1'b1) begin failed++; $display("FAIL lock_latency: got valid=%b, expected 1", d_out_valid); end
    settle();
    tests++; if (dv_seen - d0 != 1) begin failed++; $display("FAIL lock_words: got %0d, expected 1", dv_seen - d0); end
    tests++; if (sb_q.size() != 0) begin failed++; $display("FAIL lock_pending: got %0d left, expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_word_drop();
    int w0, d0;
    w0 = drop_seen; d0 = dv_seen;
    send_sym(C_A5, 1'b0);
    send_sym(K_NEG, 1'b0); settle();
    tests++; if (drop_seen - w0 != 1) begin failed++; $display("FAIL drop_pulse: got %0d, expected 1", drop_seen - w0); end
    tests++; if (dv_seen != d0) begin failed++; $display("FAIL drop_word: got %0d words, expected 0", dv_seen - d0); end
    tests++; if (locked !== 1'b1) begin failed++; $display("FAIL drop_locked: got %b, expected 1", locked); end
    send_sym(K_NEG, 1'b0); settle();
    tests++; if (drop_seen - w0 != 1) begin failed++; $display("FAIL drop_empty: got %0d, expected 1", drop_seen - w0); end
    sb_q.push_back('{16'hFF00, 1'b0});
    send_sym(C_00, 1'b0);
    send_sym(C_FF, 1'b0); settle();
    tests++; if (sb_q.size() != 0) begin failed++; $display("FAIL drop_pending: got %0d left, expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [9:0] syms[6] = '{C_A5, C_3C, C_FF, C_A5, C_3C, C_00};
    int d0;
    d0 = dv_seen;
    sb_q.push_back('{16'h3CA5, 1'b0});
    sb_q.push_back('{16'hA5FF, 1'b0});
    sb_q.push_back('{16'h003C, 1'b0});
    foreach (syms[i]) send_sym(syms[i], 1'b0);
    settle();
    tests++; if (dv_seen - d0 != 3) begin failed++; $display("FAIL b2b_words: got %0d, expected 3", dv_seen - d0); end
    tests++; if (sb_q.size() != 0) begin failed++; $display("FAIL b2b_pending: got %0d left, expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_loss();
    int r0, w0;
    r0 = reframe_seen; w0 = drop_seen;
    // Each misaligned comma straddles one symbol boundary; those junk symbols pack into two words.
    sb_q.push_back('{16'h0, 1'b1});
    sb_q.push_back('{16'h0, 1'b1});
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    repeat (3) send_sym(K_NEG, 1'b0);
    settle();
    tests++; if (locked !== 1'b1) begin failed++; $display("FAIL loss_early: got %b, expected 1", locked); end
    send_sym(K_NEG, 1'b0); settle();
    tests++; if (locked !== 1'b0) begin failed++; $display("FAIL loss_fall: got %b, expected 0", locked); end
    tests++; if (reframe_seen != r0) begin failed++; $display("FAIL loss_reframe: got %0d, expected 0", reframe_seen - r0); end
    tests++; if (drop_seen != w0) begin failed++; $display("FAIL loss_drop: got %0d, expected 0", drop_seen - w0); end
    tests++; if (sb_q.size() != 0) begin failed++; $display("FAIL loss_words: got %0d missing, expected 0", sb_q.size()); end
    sb_q.delete();
    send_sym(K_NEG, 1'b0); settle();
    tests++; if (reframe_seen - r0 != 1) begin failed++; $display("FAIL hunt_reframe: got %0d, expected 1", reframe_seen - r0); end
  endtask

  task automatic test_reset_mid_word();
    int w0;
    send_sym(K_NEG, 1'b0);
    send_sym(K_NEG, 1'b0); settle();
    tests++; if (locked !== 1'b1) begin failed++; $display("FAIL mid_relock: got %b, expected 1", locked); end
    send_sym(C_A5, 1'b0);
    w0 = drop_seen;
    @(negedge clk_x8); rst_n = 1'b0;
    @(negedge clk_x8);
    tests++; if (d_out !== 16'h0 || d_out_valid !== 1'b0 || locked !== 1'b0 || reframe !== 1'b0 || word_drop !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset: got d_out=%h dv=%b locked=%b reframe=%b drop=%b, expected all 0",
               d_out, d_out_valid, locked, reframe, word_drop);
    end
    rst_n = 1'b1;
    settle(); settle();
    tests++; if (drop_seen != w0) begin failed++; $display("FAIL mid_drop: got %0d, expected 0", drop_seen - w0); end
  endtask

`ifdef RX_DEFRAMER_STATS_EN
  task automatic test_stats();
    send_sym(K_NEG, 1'b0);
    send_sym(K_NEG, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    repeat (3) send_sym(K_NEG, 1'b0);
    settle();
    tests++; if (comma_cnt !== 16'd5) begin failed++; $display("FAIL stats_comma: got %0d, expected 5", comma_cnt); end
    tests++; if (realign_cnt !== 16'd2) begin failed++; $display("FAIL stats_realign: got %0d, expected 2", realign_cnt); end
    tests++; if (locked !== 1'b1) begin failed++; $display("FAIL stats_locked: got %b, expected 1", locked); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_lock();
    test_word_drop();
    test_back_to_back();
    test_loss();
    test_reset_mid_word();
`ifdef RX_DEFRAMER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
